// File: rtl/loop_buffer_ctrl_pkg.sv
// Shared loop-buffer definitions: FSM encodings, default depth and the
// control-transfer opcodes also decoded by the stream loop detector.
package loop_buffer_ctrl_pkg;

  localparam int unsigned LB_DEPTH = 32;

  localparam logic [1:0] LB_IDLE   = 2'd0;
  localparam logic [1:0] LB_FILL   = 2'd1;
  localparam logic [1:0] LB_PRIME  = 2'd2;
  localparam logic [1:0] LB_REPLAY = 2'd3;

  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_BTYPE = 7'b1100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  // True for any instruction that redirects fetch.
  function automatic logic is_ctrl_xfer(input logic [31:0] instr);
    return (instr[6:0] == OPC_JAL) || (instr[6:0] == OPC_BTYPE) ||
           (instr[6:0] == OPC_JALR);
  endfunction

endpackage

// File: rtl/loop_buffer_bram.sv
// Loop-buffer storage: single read/write port, registered read data.
// Read data holds while the port is idle or writing, so a stalled replay
// keeps presenting the last fetched entry.
module loop_buffer_bram #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write or read one entry per enabled cycle.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/loop_buffer_ctrl.sv
// Loop-buffer controller: captures a loop body from IFID, then replays it
// from the BRAM while normal fetch is blocked, until the loop exit resolves.
module loop_buffer_ctrl
  import loop_buffer_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = LB_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_buf_i,
  input  logic [31:0]       loop_pc_i,
  input  logic              close_buf_i,
  input  logic              abort_buf_i,
  input  logic              mispredict_i,
  input  logic              stall_i,
  input  logic              ifid_valid_i,
  input  logic [DATA_W-1:0] ifid_instr_i,
  input  logic [31:0]       ifid_pc_i,
  output logic              bram_en_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_wdata_o,
  input  logic [DATA_W-1:0] bram_rdata_i,
  output logic              rep_valid_o,
  output logic [DATA_W-1:0] rep_instr_o,
  output logic [31:0]       rep_pc_o,
  output logic              fetch_block_o,
  output logic              release_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W+1)'(1);

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;   // entry being read this cycle
  logic [ADDR_W-1:0] rd_idx_q,    rd_idx_d;   // entry whose data is on rdata
  logic [ADDR_W:0]   len_q,       len_d;
  logic [31:0]       base_pc_q,   base_pc_d;
  logic              rep_valid_q, rep_valid_d;
  logic [DATA_W-1:0] rep_instr_q, rep_instr_d;
  logic [31:0]       rep_pc_q,    rep_pc_d;
  logic              release_q,   release_d;
  logic              overflow_q,  overflow_d;
  logic [ADDR_W:0]   last_rd;

  // Replay PCs are rebuilt from loop_pc, so the IFID PC is not needed.
  logic unused_ifid_pc;
  assign unused_ifid_pc = ^ifid_pc_i;

  assign last_rd = len_q - LEN_ONE;

  // Next-state, pointer and BRAM port decode.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_idx_d     = rd_idx_q;
    len_d        = len_q;
    base_pc_d    = base_pc_q;
    rep_valid_d  = rep_valid_q;
    rep_instr_d  = rep_instr_q;
    rep_pc_d     = rep_pc_q;
    release_d    = 1'b0;
    overflow_d   = 1'b0;
    bram_en_o    = 1'b0;
    bram_we_o    = 1'b0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    case (state_q)
      LB_IDLE: begin
        if (start_buf_i && !mispredict_i && !abort_buf_i) begin
          base_pc_d = loop_pc_i;
          wr_ptr_d  = '0;
          state_d   = LB_FILL;
        end
      end
      LB_FILL: begin
        if (mispredict_i || abort_buf_i) begin
          // Drop the partial body; the write this cycle is suppressed.
          release_d = 1'b1;
          state_d   = LB_IDLE;
        end else if (ifid_valid_i) begin
          bram_en_o    = 1'b1;
          bram_we_o    = 1'b1;
          bram_addr_o  = wr_ptr_q;
          bram_wdata_o = ifid_instr_i;
          wr_ptr_d     = wr_ptr_q + PTR_ONE;
          if (close_buf_i) begin
            // The closing branch is the last body entry.
            len_d   = {1'b0, wr_ptr_q} + LEN_ONE;
            state_d = LB_PRIME;
          end else if (wr_ptr_q == LAST_ENTRY) begin
            overflow_d = 1'b1;
            release_d  = 1'b1;
            wr_ptr_d   = '0;
            state_d    = LB_IDLE;
          end
        end
      end
      LB_PRIME: begin
        if (mispredict_i || abort_buf_i) begin
          release_d = 1'b1;
          state_d   = LB_IDLE;
        end else begin
          // Pre-read entry 0 so REPLAY has data on its first cycle.
          bram_en_o   = 1'b1;
          bram_addr_o = '0;
          rd_idx_d    = '0;
          rd_ptr_d    = (len_q == LEN_ONE) ? '0 : PTR_ONE;
          state_d     = LB_REPLAY;
        end
      end
      default: begin  // LB_REPLAY
        if (mispredict_i) begin
          release_d   = 1'b1;
          rep_valid_d = 1'b0;
          rep_instr_d = '0;
          rep_pc_d    = '0;
          state_d     = LB_IDLE;
        end else if (!stall_i) begin
          rep_valid_d = 1'b1;
          rep_instr_d = bram_rdata_i;
          rep_pc_d    = base_pc_q + 32'({rd_idx_q, 2'b00});
          bram_en_o   = 1'b1;
          bram_addr_o = rd_ptr_q;
          rd_idx_d    = rd_ptr_q;
          rd_ptr_d    = ({1'b0, rd_ptr_q} == last_rd) ? '0 : rd_ptr_q + PTR_ONE;
        end
      end
    endcase
  end

  // State, pointers and registered outputs; reset clears everything.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= LB_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_idx_q    <= '0;
      len_q       <= '0;
      base_pc_q   <= '0;
      rep_valid_q <= 1'b0;
      rep_instr_q <= '0;
      rep_pc_q    <= '0;
      release_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_idx_q    <= rd_idx_d;
      len_q       <= len_d;
      base_pc_q   <= base_pc_d;
      rep_valid_q <= rep_valid_d;
      rep_instr_q <= rep_instr_d;
      rep_pc_q    <= rep_pc_d;
      release_q   <= release_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rep_valid_o   = rep_valid_q;
  assign rep_instr_o   = rep_instr_q;
  assign rep_pc_o      = rep_pc_q;
  assign release_o     = release_q;
  assign overflow_o    = overflow_q;
  assign fetch_block_o = (state_q == LB_PRIME) || (state_q == LB_REPLAY);

endmodule

// File: tb/tb_loop_buffer_ctrl.sv
// Directed bench for loop_buffer_ctrl with the loop-buffer BRAM attached.
module tb_loop_buffer_ctrl;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start_buf, close_buf, abort_buf, mispredict, stall, ifid_valid;
  logic [31:0]       loop_pc, ifid_pc;
  logic [DATA_W-1:0] ifid_instr;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata, bram_rdata;
  logic              rep_valid, fetch_block, rel, overflow;
  logic [DATA_W-1:0] rep_instr;
  logic [31:0]       rep_pc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  loop_buffer_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .reset_ni(reset_n), .start_buf_i(start_buf), .loop_pc_i(loop_pc),
    .close_buf_i(close_buf), .abort_buf_i(abort_buf), .mispredict_i(mispredict),
    .stall_i(stall), .ifid_valid_i(ifid_valid), .ifid_instr_i(ifid_instr),
    .ifid_pc_i(ifid_pc), .bram_en_o(bram_en), .bram_we_o(bram_we),
    .bram_addr_o(bram_addr), .bram_wdata_o(bram_wdata), .bram_rdata_i(bram_rdata),
    .rep_valid_o(rep_valid), .rep_instr_o(rep_instr), .rep_pc_o(rep_pc),
    .fetch_block_o(fetch_block), .release_o(rel), .overflow_o(overflow)
  );

  loop_buffer_bram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bram (
    .clk_i(clk), .en_i(bram_en), .we_i(bram_we), .addr_i(bram_addr),
    .wdata_i(bram_wdata), .rdata_o(bram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rep(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(rep_valid), 32'(v));
    chk({tag, ".instr"}, rep_instr, ins);
    chk({tag, ".pc"}, rep_pc, pc);
  endtask

  initial begin
    reset_n = 1'b0; start_buf = 0; close_buf = 0; abort_buf = 0; mispredict = 0;
    stall = 0; ifid_valid = 0; loop_pc = '0; ifid_pc = '0; ifid_instr = '0;

    // Reset state
    #2;
    chk_rep("rst", 1'b0, 32'h0, 32'h0);
    chk("rst.fetch_block", 32'(fetch_block), 32'd0);
    chk("rst.release", 32'(rel), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.bram_en", 32'(bram_en), 32'd0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;

    // 1: 4-entry body at 0x100, close on the 4th
    start_buf = 1; loop_pc = 32'h100; tick(); start_buf = 0;
    for (int k = 0; k < 4; k++) begin
      ifid_valid = 1; ifid_instr = 32'hA000_0000 + k; ifid_pc = 32'h100 + 4*k;
      close_buf = (k == 3);
      @(negedge clk);
      chk($sformatf("t1.we%0d", k), 32'(bram_we), 32'd1);
      chk($sformatf("t1.addr%0d", k), 32'(bram_addr), k);
      chk($sformatf("t1.fb%0d", k), 32'(fetch_block), 32'd0);
      tick();
    end
    ifid_valid = 0; close_buf = 0;
    @(negedge clk);                                  // PRIME
    chk("t1.prime.fb", 32'(fetch_block), 32'd1);
    chk("t1.prime.en", 32'(bram_en), 32'd1);
    chk("t1.prime.we", 32'(bram_we), 32'd0);
    chk("t1.prime.addr", 32'(bram_addr), 32'd0);
    tick();
    @(negedge clk);                                  // first REPLAY cycle
    chk("t1.r0.valid", 32'(rep_valid), 32'd0);
    tick();
    for (int j = 0; j < 6; j++) begin
      start_buf = (j == 2); loop_pc = 32'hF00;       // ignored outside IDLE
      @(negedge clk);
      chk_rep($sformatf("t1.rep%0d", j), 1'b1, 32'hA000_0000 + (j % 4), 32'h100 + 4*(j % 4));
      tick();
    end
    start_buf = 0;

    // 2: stall 3 cycles while entry 2 is on the outputs
    stall = 1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk_rep($sformatf("t2.stall%0d", s), 1'b1, 32'hA000_0002, 32'h108);
      chk($sformatf("t2.en%0d", s), 32'(bram_en), 32'd0);
      tick();
    end
    stall = 0;
    @(negedge clk);
    chk_rep("t2.resume", 1'b1, 32'hA000_0002, 32'h108);
    tick();
    @(negedge clk); chk_rep("t2.next3", 1'b1, 32'hA000_0003, 32'h10C); tick();
    @(negedge clk); chk_rep("t2.next0", 1'b1, 32'hA000_0000, 32'h100); tick();
    @(negedge clk); chk_rep("t2.next1", 1'b1, 32'hA000_0001, 32'h104);
    mispredict = 1; tick(); mispredict = 0;
    @(negedge clk);
    chk("t2.exit.release", 32'(rel), 32'd1);
    tick();

    // 3: mispredict on the 6th replayed instruction
    start_buf = 1; loop_pc = 32'h200; tick(); start_buf = 0;
    for (int k = 0; k < 4; k++) begin
      ifid_valid = 1; ifid_instr = 32'hB000_0000 + k; close_buf = (k == 3); tick();
    end
    ifid_valid = 0; close_buf = 0;
    tick(); tick();                                  // PRIME, first REPLAY
    for (int j = 0; j < 6; j++) begin
      mispredict = (j == 5);
      @(negedge clk);
      chk_rep($sformatf("t3.rep%0d", j), 1'b1, 32'hB000_0000 + (j % 4), 32'h200 + 4*(j % 4));
      tick();
    end
    mispredict = 0;
    @(negedge clk);
    chk("t3.release", 32'(rel), 32'd1);
    chk("t3.fetch_block", 32'(fetch_block), 32'd0);
    chk("t3.rep_valid", 32'(rep_valid), 32'd0);
    chk("t3.bram_en", 32'(bram_en), 32'd0);
    tick();
    @(negedge clk);
    chk("t3.release_end", 32'(rel), 32'd0);
    chk("t3.overflow", 32'(overflow), 32'd0);
    tick();

    // 4: 32 writes without close -> overflow
    start_buf = 1; loop_pc = 32'h300; tick(); start_buf = 0;
    for (int k = 0; k < 32; k++) begin
      ifid_valid = 1; ifid_instr = 32'hD000_0000 + k;
      if (k == 31) begin
        @(negedge clk);
        chk("t4.we31", 32'(bram_we), 32'd1);
        chk("t4.addr31", 32'(bram_addr), 32'd31);
        chk("t4.ovf_pre", 32'(overflow), 32'd0);
      end
      tick();
    end
    ifid_valid = 0;
    @(negedge clk);
    chk("t4.overflow", 32'(overflow), 32'd1);
    chk("t4.release", 32'(rel), 32'd1);
    chk("t4.fetch_block", 32'(fetch_block), 32'd0);
    tick();
    ifid_valid = 1; ifid_instr = 32'hEEEE_EEEE;     // IDLE: must not write
    @(negedge clk);
    chk("t4.overflow_end", 32'(overflow), 32'd0);
    chk("t4.release_end", 32'(rel), 32'd0);
    chk("t4.idle_en", 32'(bram_en), 32'd0);
    tick(); ifid_valid = 0; tick();
    @(negedge clk);
    chk("t4.no_replay.fb", 32'(fetch_block), 32'd0);
    chk("t4.no_replay.valid", 32'(rep_valid), 32'd0);
    tick();

    // 5: close_buf and abort_buf together -> abort wins
    start_buf = 1; loop_pc = 32'h400; tick(); start_buf = 0;
    for (int k = 0; k < 2; k++) begin
      ifid_valid = 1; ifid_instr = 32'h5000_0000 + k; tick();
    end
    close_buf = 1; abort_buf = 1; ifid_instr = 32'h5000_0002;
    @(negedge clk);
    chk("t5.we_suppressed", 32'(bram_we), 32'd0);
    chk("t5.en_suppressed", 32'(bram_en), 32'd0);
    tick();
    close_buf = 0; abort_buf = 0; ifid_valid = 0;
    @(negedge clk);
    chk("t5.release", 32'(rel), 32'd1);
    chk("t5.no_prime.fb", 32'(fetch_block), 32'd0);
    chk("t5.no_prime.en", 32'(bram_en), 32'd0);
    tick();
    @(negedge clk);
    chk("t5.release_end", 32'(rel), 32'd0);
    chk("t5.overflow", 32'(overflow), 32'd0);
    tick();

    // 6: single-entry loop, then reset mid-replay
    start_buf = 1; loop_pc = 32'h500; tick(); start_buf = 0;
    ifid_valid = 1; close_buf = 1; ifid_instr = 32'hC000_0000; tick();
    ifid_valid = 0; close_buf = 0;
    tick(); tick();                                  // PRIME, first REPLAY
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk_rep($sformatf("t6.rep%0d", j), 1'b1, 32'hC000_0000, 32'h500);
      chk($sformatf("t6.addr%0d", j), 32'(bram_addr), 32'd0);
      if (j < 3) tick();
    end
    #2 reset_n = 1'b0;
    #1;
    chk_rep("t6.rst", 1'b0, 32'h0, 32'h0);
    chk("t6.rst.fb", 32'(fetch_block), 32'd0);
    chk("t6.rst.en", 32'(bram_en), 32'd0);
    chk("t6.rst.release", 32'(rel), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    chk("t6.post.valid", 32'(rep_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
